// File: rtl/cam_pixel_bridge.sv
// cam_pixel_bridge: camera {Y,U/V} pixels -> RGB565 tagged with linear index, FIFO-buffered valid/ready output.
// Latency: in_valid at N -> FIFO write N+1 -> out_valid N+2; input never stalls, a full FIFO drops the pixel (sticky overflow).
// Optional colour-bar generator enabled by defining CAM_BRIDGE_TESTPAT_EN.

module cam_pixel_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module cam_pixel_bridge #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 16,
    localparam int IDX_W     = $clog2(H_RES*V_RES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [7:0]       threshold,
    input  logic             frame_start,
`ifdef CAM_BRIDGE_TESTPAT_EN
    input  logic             test_pattern,
`endif
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             overflow,
    output logic             frame_err,
    output logic [15:0]      frame_count
);
    localparam int TOTAL = H_RES * V_RES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
    localparam int EW = 1 + IDX_W + 16;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_nxt;
    logic             take;
    logic             start_acc;
    logic             restart;

    logic [1:0]       mode_q;
    logic [7:0]       thr_q;
    logic [15:0]      pix;

    logic             pipe_vld;
    logic [15:0]      pipe_dat;
    logic [IDX_W-1:0] pipe_idx;
    logic             pipe_last;

    logic [EW-1:0]    fifo_din;
    logic [EW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        start_acc = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                    start_acc = 1'b1;
                end
            end
            ACTIVE: begin
                // A new frame_start aborts the current frame; its pixels already queued still drain.
                if (frame_start) begin
                    cnt_nxt = '0;
                    restart = 1'b1;
                end else if (in_valid) begin
                    take = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = FLUSH;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (fifo_empty && !pipe_vld) begin
                    if (frame_start) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = '0;
                        start_acc = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 2'd0;
            thr_q  <= 8'd0;
        end else if (start_acc) begin
            mode_q <= mode;
            thr_q  <= threshold;
        end
    end

`ifdef CAM_BRIDGE_TESTPAT_EN
    localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int BAR_W = (H_RES >= 8) ? (H_RES / 8) : 1;

    logic          tp_q;
    logic [XW-1:0] col;
    logic [15:0]   bar_pix;
    int            bar;

    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q <= 1'b0;
            col  <= '0;
        end else begin
            if (start_acc) tp_q <= test_pattern;
            if (start_acc || restart) begin
                col <= '0;
            end else if (take) begin
                col <= (int'(col) == H_RES - 1) ? '0 : col + 1'b1;
            end
        end
    end

    always_comb begin
        bar = int'(col) / BAR_W;
        if (bar > 7) bar = 7;
        case (bar)
            0:       bar_pix = 16'hFFFF;
            1:       bar_pix = 16'hFFE0;
            2:       bar_pix = 16'h07FF;
            3:       bar_pix = 16'h07E0;
            4:       bar_pix = 16'hF81F;
            5:       bar_pix = 16'hF800;
            6:       bar_pix = 16'h001F;
            default: bar_pix = 16'h0000;
        endcase
    end
`endif

    always_comb begin
        case (mode_q)
            2'd1:    pix = in_data;
            2'd2:    pix = (in_data[15:8] >= thr_q) ? 16'hFFFF : 16'h0000;
            default: pix = {in_data[15:11], in_data[15:10], in_data[15:11]};
        endcase
`ifdef CAM_BRIDGE_TESTPAT_EN
        if (tp_q) pix = bar_pix;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld  <= 1'b0;
            pipe_dat  <= '0;
            pipe_idx  <= '0;
            pipe_last <= 1'b0;
        end else begin
            pipe_vld <= take;
            if (take) begin
                pipe_dat  <= pix;
                pipe_idx  <= cnt;
                pipe_last <= (cnt == LAST_IDX);
            end
        end
    end

    assign fifo_din = {pipe_last, pipe_idx, pipe_dat};
    assign pop      = out_valid && out_ready;

    cam_pixel_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pipe_vld),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields are masked while empty so stale storage never shows on the outputs.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_dout[15:0] : 16'h0000;
    assign out_index = out_valid ? fifo_dout[16 +: IDX_W] : '0;
    assign out_last  = out_valid && fifo_dout[EW-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            if (pipe_vld && fifo_full && !pop) overflow <= 1'b1;
            if (restart) frame_err <= 1'b1;
            if (pop && out_last) frame_count <= frame_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_cam_pixel_bridge.sv
// Scoreboard bench for cam_pixel_bridge at H_RES=4, V_RES=2, FIFO_DEPTH=4 (plus an 8x1 colour-bar instance when CAM_BRIDGE_TESTPAT_EN is defined).
module tb_cam_pixel_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  threshold = 8'd0;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  i;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cam_pixel_bridge #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .threshold   (threshold),
        .frame_start (frame_start),
`ifdef CAM_BRIDGE_TESTPAT_EN
        .test_pattern(1'b0),
`endif
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on every handshake and check stall stability.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic [2:0]  prev_i;
    logic        prev_l;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {16'd0, out_data}, {16'd0, prev_d});
                chk("stall_index", {29'd0, out_index}, {29'd0, prev_i});
                chk("stall_last", {31'd0, out_last}, {31'd0, prev_l});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {29'd0, out_index}, 32'hFFFFFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("pop_index", {29'd0, out_index}, {29'd0, e.i});
                    chk("pop_last", {31'd0, out_last}, {31'd0, e.l});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_i = out_index;
            prev_l = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_pix(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_pix(input logic [15:0] d, input logic [2:0] i, input logic l);
        exp_t e;
        e.d = d;
        e.i = i;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_drain_timeout"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

`ifdef CAM_BRIDGE_TESTPAT_EN
    logic        tp_fs = 1'b0;
    logic        tp_vld = 1'b0;
    logic        tp_out_valid;
    logic [15:0] tp_out_data;
    logic [2:0]  tp_out_index;
    logic        tp_out_last;
    logic        tp_overflow;
    logic        tp_frame_err;
    logic [15:0] tp_frame_count;
    logic [15:0] tp_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    cam_pixel_bridge #(.H_RES(8), .V_RES(1), .FIFO_DEPTH(4)) dut_tp (
        .clk         (clk),
        .reset       (reset),
        .mode        (2'd1),
        .threshold   (8'd0),
        .frame_start (tp_fs),
        .test_pattern(1'b1),
        .in_valid    (tp_vld),
        .in_data     (16'h1234),
        .out_valid   (tp_out_valid),
        .out_ready   (1'b1),
        .out_data    (tp_out_data),
        .out_index   (tp_out_index),
        .out_last    (tp_out_last),
        .overflow    (tp_overflow),
        .frame_err   (tp_frame_err),
        .frame_count (tp_frame_count)
    );

    task automatic run_testpat();
        int got = 0;
        tp_fs = 1'b1;
        tick();
        tp_fs = 1'b0;
        tp_vld = 1'b1;
        repeat (8) tick();
        tp_vld = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (tp_out_valid) begin
                chk("tp_data", {16'd0, tp_out_data}, {16'd0, tp_tab[got]});
                got++;
            end
        end
        chk("tp_pop_count", got, 32'd8);
        tick();
        chk("tp_frame_count", {16'd0, tp_frame_count}, 32'd1);
    endtask
`endif

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: gray frame, Y=FF -> FFFF
        out_ready = 1'b1;
        mode = 2'd0;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            expect_pix(16'hFFFF, 3'(i), i == 7);
            send_pix(16'hFF00);
        end
        wait_drain("t1");
        chk("t1_frame_count", {16'd0, frame_count}, 32'd1);
        send_pix(16'h1200);
        send_pix(16'h3400);
        repeat (4) tick();
        chk("t1_idle_ignores", {31'd0, out_valid}, 32'd0);

        // 2: threshold mode
        mode = 2'd2;
        threshold = 8'h80;
        start_frame();
        expect_pix(16'h0000, 3'd0, 1'b0); send_pix(16'h7F00);
        expect_pix(16'hFFFF, 3'd1, 1'b0); send_pix(16'h8000);
        expect_pix(16'h0000, 3'd2, 1'b0); send_pix(16'h0000);
        expect_pix(16'hFFFF, 3'd3, 1'b0); send_pix(16'hFF00);
        for (int i = 4; i < 8; i++) begin
            expect_pix(16'h0000, 3'(i), i == 7);
            send_pix(16'h0055);
        end
        wait_drain("t2");
        chk("t2_frame_count", {16'd0, frame_count}, 32'd2);

        // 3: overflow with passthrough data
        mode = 2'd1;
        out_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) expect_pix(16'hA000 + 16'(i), 3'(i), 1'b0);
            send_pix(16'hA000 + 16'(i));
        end
        repeat (2) tick();
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        wait_drain("t3");
        chk("t3_frame_count", {16'd0, frame_count}, 32'd2);

        // 4: short frame, Y=08 -> 0841
        mode = 2'd0;
        chk("t4_frame_err_before", {31'd0, frame_err}, 32'd0);
        start_frame();
        for (int i = 0; i < 3; i++) begin
            expect_pix(16'h0841, 3'(i), 1'b0);
            send_pix(16'h0800);
        end
        start_frame();
        for (int i = 0; i < 8; i++) begin
            expect_pix(16'h0841, 3'(i), i == 7);
            send_pix(16'h0800);
        end
        wait_drain("t4");
        chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t4_frame_count", {16'd0, frame_count}, 32'd3);

        // 5: toggling back-pressure, then reset mid-frame
        mode = 2'd1;
        out_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            expect_pix(16'hB000 + 16'(i), 3'(i), i == 7);
            in_valid = 1'b1;
            in_data = 16'hB000 + 16'(i);
            out_ready = ~out_ready;
            tick();
            in_valid = 1'b0;
            out_ready = ~out_ready;
            tick();
        end
        repeat (6) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        wait_drain("t5");
        chk("t5_frame_count", {16'd0, frame_count}, 32'd4);
        out_ready = 1'b0;
        start_frame();
        send_pix(16'hC000);
        send_pix(16'hC001);
        send_pix(16'hC002);
        repeat (2) tick();
        chk("t5_pre_reset_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_out_data", {16'd0, out_data}, 32'd0);
        chk("t5_rst_out_index", {29'd0, out_index}, 32'd0);
        chk("t5_rst_out_last", {31'd0, out_last}, 32'd0);
        chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("t5_rst_frame_count", {16'd0, frame_count}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

`ifdef CAM_BRIDGE_TESTPAT_EN
        run_testpat();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
